// File: rtl/wishbone_timer_slave_if.sv
// Wishbone bus bundle between the CPU-side master and the timer slave.
// Latency: none, wires only.
// Backpressure: the slave holds off the master by delaying ack_o; the master keeps stb_i up until then.
//
// Signals:
//   adr_i   16-bit address        (master -> slave)
//   dat_i   8-bit write data      (master -> slave)
//   dat_o   8-bit read data       (slave -> master)
//   we_i    1 = write, 0 = read   (master -> slave)
//   stb_i   strobe                (master -> slave)
//   cyc_i   bus cycle             (master -> slave)
//   ack_o   acknowledge           (slave -> master)
interface wishbone_timer_slave_if;
    logic [15:0] adr_i;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;

    modport master (
        output adr_i, dat_i, we_i, stb_i, cyc_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, stb_i, cyc_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/wishbone_timer_slave.sv
// 8-bit Wishbone slave: 16-bit timer with prescaler, compare match and level interrupt.
// Latency: one wait state -- ack_o and read data one cycle after a selected strobe, single-cycle pulse.
// Backpressure: none beyond the wait state; a held strobe gets a new access every second cycle.
//
// Ports:
//   clk_i  system clock, all state on the rising edge
//   rst_i  asynchronous active-low reset
//   bus    Wishbone slave modport (adr/dat/we/stb/cyc in, dat_o/ack_o out)
//   irq_o  interrupt request, MATCH & IRQ_EN
//
// Register map (offset from BASE, window of 8 bytes):
//   0 CTRL  {IRQ_EN, AUTO_RELOAD, EN}   1 PRESC
//   2 CMP_L 3 CMP_H                     4 CNT_L (read latches CNT_H shadow, write clears count)
//   5 CNT_H shadow (read-only)          6 STATUS {MATCH}, write 1 clears
//   7 reserved
module wishbone_timer_slave #(
    parameter logic [15:0] BASE = 16'h8000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    wishbone_timer_slave_if.slave        bus,
    output logic                         irq_o
);

    // ---------------- bus decode ----------------
    logic        sel;
    logic [2:0]  offset;
    logic        ack;
    logic [7:0]  rdat;
    logic        acc;
    logic        wr;
    logic        rd;
    logic [7:0]  rdata;

    assign sel    = bus.cyc_i & bus.stb_i & (bus.adr_i[15:3] == BASE[15:3]);
    assign offset = bus.adr_i[2:0];
    // An access commits only on the edge that raises ack, so a held strobe
    // produces exactly one side effect per ack pulse.
    assign acc    = sel & ~ack;
    assign wr     = acc & bus.we_i;
    assign rd     = acc & ~bus.we_i;

    assign bus.ack_o = ack;
    assign bus.dat_o = rdat;

    // ---------------- registers ----------------
    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic        match;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic [15:0] cmp;
    logic [15:0] cnt;
    logic [7:0]  shadow;

    logic        tick;
    logic        hit;
    logic        wr_ctrl;
    logic        wr_cnt_l;
    logic        wr_status;

    assign tick      = en & (pcnt == presc);
    assign hit       = tick & (cnt == cmp);
    assign wr_ctrl   = wr & (offset == 3'd0);
    assign wr_cnt_l  = wr & (offset == 3'd4);
    assign wr_status = wr & (offset == 3'd6);

    assign irq_o = match & irq_en;

    always_comb begin
        rdata = 8'h00;
        case (offset)
            3'd0:    rdata = {5'b0, irq_en, auto_reload, en};
            3'd1:    rdata = presc;
            3'd2:    rdata = cmp[7:0];
            3'd3:    rdata = cmp[15:8];
            3'd4:    rdata = cnt[7:0];
            3'd5:    rdata = shadow;
            3'd6:    rdata = {7'b0, match};
            default: rdata = 8'h00;
        endcase
    end

    // Bus response: ack pulses for one cycle, read data only alongside it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack  <= 1'b0;
            rdat <= 8'h00;
        end else begin
            ack  <= acc;
            rdat <= acc ? rdata : 8'h00;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            presc       <= 8'h00;
            cmp         <= 16'hFFFF;
        end else if (wr) begin
            case (offset)
                3'd0: begin
                    auto_reload <= bus.dat_i[1];
                    irq_en      <= bus.dat_i[2];
                end
                3'd1:    presc     <= bus.dat_i;
                3'd2:    cmp[7:0]  <= bus.dat_i;
                3'd3:    cmp[15:8] <= bus.dat_i;
                default: ;
            endcase
        end
    end

    // EN: a one-shot match stopping the timer overrides a software write on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en <= 1'b0;
        end else if (hit && !auto_reload) begin
            en <= 1'b0;
        end else if (wr_ctrl) begin
            en <= bus.dat_i[0];
        end
    end

    // MATCH: setting wins over a software clear on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && bus.dat_i[0]) begin
            match <= 1'b0;
        end
    end

    // Prescaler and counter: a CNT_L write wins over a tick on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pcnt <= 8'h00;
            cnt  <= 16'h0000;
        end else begin
            if (wr_cnt_l || !en || tick) begin
                pcnt <= 8'h00;
            end else begin
                pcnt <= pcnt + 8'd1;
            end

            if (wr_cnt_l) begin
                cnt <= 16'h0000;
            end else if (hit) begin
                if (auto_reload) begin
                    cnt <= 16'h0000;
                end
            end else if (tick) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // High byte is captured with the low-byte read so a 16-bit read is coherent.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow <= 8'h00;
        end else if (rd && offset == 3'd4) begin
            shadow <= cnt[15:8];
        end
    end

endmodule

// File: tb/tb_wishbone_timer_slave.sv
module tb_wishbone_timer_slave;

    localparam logic [15:0] BASE = 16'h8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    always #5 clk = ~clk;

    wishbone_timer_slave_if bus ();

    wishbone_timer_slave #(.BASE(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus),
        .irq_o (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      name;
        logic       ack;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [7:0]  wd;
        logic        ack;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [15:0] adr, input logic we, input logic [7:0] wd,
                                input logic ack, input logic [7:0] dat);
        vec_t v;
        v.adr = adr; v.we = we; v.wd = wd; v.ack = ack; v.dat = dat;
        return v;
    endfunction

    // Called at a negedge. Returns at the negedge one cycle after the ack was seen,
    // so that ack has fallen and the next access starts cleanly.
    task automatic access(input string name, input logic [15:0] adr, input logic we,
                          input logic [7:0] wd, input logic exp_ack, input logic [7:0] exp_dat);
        exp_t e;
        logic got;
        int   lat;
        logic [7:0] rd;
        logic [7:0] idle_or;
        e.name = name; e.ack = exp_ack; e.dat = exp_dat;
        sb.push_back(e);
        bus.adr_i = adr; bus.we_i = we; bus.dat_i = wd;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        got = 1'b0; lat = 0; rd = 8'h00; idle_or = 8'h00;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (bus.ack_o) begin
                got = 1'b1;
                lat = i;
                rd  = bus.dat_o;
            end else begin
                idle_or = idle_or | bus.dat_o;
            end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        e = sb.pop_front();
        chk({e.name, " ack"}, {15'b0, got}, {15'b0, e.ack});
        if (got) begin
            chk({e.name, " latency"}, 16'(lat), 16'd1);
            if (!we) chk({e.name, " data"}, {8'h00, rd}, {8'h00, e.dat});
        end else begin
            chk({e.name, " idle dat_o"}, {8'h00, idle_or}, 16'h0000);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        access($sformatf("wr%0d", off), BASE + {13'b0, off}, 1'b1, d, 1'b1, 8'h00);
    endtask

    task automatic rdc(input string name, input logic [2:0] off, input logic [7:0] exp);
        access(name, BASE + {13'b0, off}, 1'b0, 8'h00, 1'b1, exp);
    endtask

    initial begin
        logic [5:0] pat;
        bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0;
        bus.stb_i = 1'b0; bus.cyc_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("reset ack", {15'b0, bus.ack_o}, 16'h0);
        chk("reset dat", {8'h0, bus.dat_o}, 16'h0);
        chk("reset irq", {15'b0, irq}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven register access ----------------
        tbl.push_back(mk(BASE + 16'd0, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd1, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 8'hFF));
        tbl.push_back(mk(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 8'hFF));
        tbl.push_back(mk(BASE + 16'd4, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd5, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd6, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd7, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd1, 1'b1, 8'h5A, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd1, 1'b0, 8'h00, 1'b1, 8'h5A));
        tbl.push_back(mk(BASE + 16'd0, 1'b1, 8'hF8, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd0, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd0, 1'b1, 8'h06, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd0, 1'b0, 8'h00, 1'b1, 8'h06));
        tbl.push_back(mk(BASE + 16'd0, 1'b1, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd2, 1'b1, 8'h34, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 8'h34));
        tbl.push_back(mk(BASE + 16'd3, 1'b1, 8'h12, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 8'h12));
        tbl.push_back(mk(BASE + 16'd5, 1'b1, 8'h33, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd5, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd7, 1'b1, 8'hAA, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd7, 1'b0, 8'h00, 1'b1, 8'h00));
        tbl.push_back(mk(BASE + 16'd9, 1'b1, 8'h11, 1'b0, 8'h00));
        tbl.push_back(mk(BASE + 16'd8, 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(16'h0000,     1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(16'h7FFF,     1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(BASE + 16'd1, 1'b0, 8'h00, 1'b1, 8'h5A));
        foreach (tbl[i])
            access($sformatf("vec%0d", i), tbl[i].adr, tbl[i].we, tbl[i].wd, tbl[i].ack, tbl[i].dat);

        // Strobe without cycle: no ack, no commit.
        bus.adr_i = BASE + 16'd1; bus.we_i = 1'b1; bus.dat_i = 8'h77;
        bus.stb_i = 1'b1; bus.cyc_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no-cyc ack", {15'b0, bus.ack_o}, 16'h0);
        end
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
        @(negedge clk);
        rdc("no-cyc presc", 3'd1, 8'h5A);

        // ---------------- prescaled auto-reload ----------------
        wr(3'd1, 8'h03); wr(3'd2, 8'h04); wr(3'd3, 8'h00); wr(3'd4, 8'h00); wr(3'd6, 8'h01);
        wr(3'd0, 8'h07);                         // commits at E0, back at negedge after E1
        repeat (15) @(negedge clk);              // after E16
        rdc("presc cnt16", 3'd4, 8'h04);         // commits E17
        @(negedge clk);
        chk("presc irq E19", {15'b0, irq}, 16'h0);
        @(negedge clk);
        chk("presc irq E20", {15'b0, irq}, 16'h1);
        wr(3'd6, 8'h01);                         // clears at E21
        chk("presc irq cleared", {15'b0, irq}, 16'h0);
        repeat (17) @(negedge clk);
        chk("presc irq E39", {15'b0, irq}, 16'h0);
        @(negedge clk);
        chk("presc irq E40", {15'b0, irq}, 16'h1);

        // ---------------- one-shot + irq ----------------
        wr(3'd0, 8'h00); wr(3'd6, 8'h01); wr(3'd1, 8'h00);
        wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd4, 8'h00);
        wr(3'd0, 8'h05);
        @(negedge clk);
        chk("oneshot irq E2", {15'b0, irq}, 16'h0);
        @(negedge clk);
        chk("oneshot irq E3", {15'b0, irq}, 16'h1);
        rdc("oneshot ctrl", 3'd0, 8'h04);
        rdc("oneshot cnt_l", 3'd4, 8'h02);
        rdc("oneshot cnt_h", 3'd5, 8'h00);
        wr(3'd6, 8'h01);
        chk("oneshot irq clr", {15'b0, irq}, 16'h0);

        // ---------------- atomic 16-bit read ----------------
        wr(3'd2, 8'hFF); wr(3'd3, 8'hFF); wr(3'd4, 8'h00);
        wr(3'd0, 8'h01);
        repeat (510) @(negedge clk);             // after E511, cnt = 0x1FF
        rdc("atomic cnt_l", 3'd4, 8'hFF);        // E512
        rdc("atomic cnt_h", 3'd5, 8'h01);        // E514, cnt already 0x201
        rdc("atomic cnt_l2", 3'd4, 8'h03);       // E516
        rdc("atomic cnt_h2", 3'd5, 8'h02);

        // ---------------- match set vs STATUS clear ----------------
        wr(3'd0, 8'h00); wr(3'd6, 8'h01); wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd4, 8'h00);
        wr(3'd0, 8'h05);
        @(negedge clk);                          // after E2
        wr(3'd6, 8'h01);                         // clear lands on match edge E3
        chk("collide irq", {15'b0, irq}, 16'h1);
        rdc("collide status", 3'd6, 8'h01);

        // ---------------- CNT_L write vs tick ----------------
        wr(3'd0, 8'h00); wr(3'd6, 8'h01); wr(3'd1, 8'h03);
        wr(3'd2, 8'hFF); wr(3'd3, 8'hFF); wr(3'd4, 8'h00);
        wr(3'd0, 8'h01);
        repeat (6) @(negedge clk);               // after E7
        wr(3'd4, 8'h00);                         // lands on tick edge E8
        rdc("tickclr cnt_l", 3'd4, 8'h00);
        rdc("tickclr cnt_h", 3'd5, 8'h00);

        // ---------------- held strobe on STATUS ----------------
        wr(3'd0, 8'h00);
        pat = 6'b010101;
        bus.adr_i = BASE + 16'd6; bus.we_i = 1'b1; bus.dat_i = 8'h01;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("held ack%0d", i), {15'b0, bus.ack_o}, {15'b0, pat[i]});
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-access ----------------
        wr(3'd1, 8'h00); wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd4, 8'h00);
        wr(3'd0, 8'h05);
        repeat (3) @(negedge clk);
        chk("pre-reset irq", {15'b0, irq}, 16'h1);
        bus.adr_i = BASE + 16'd2; bus.we_i = 1'b0;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        @(negedge clk);
        chk("pre-reset ack", {15'b0, bus.ack_o}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset ack", {15'b0, bus.ack_o}, 16'h0);
        chk("midreset dat", {8'h0, bus.dat_o}, 16'h0);
        chk("midreset irq", {15'b0, irq}, 16'h0);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rdc("post-reset cmp_l", 3'd2, 8'hFF);
        rdc("post-reset ctrl", 3'd0, 8'h00);
        rdc("post-reset status", 3'd6, 8'h00);
        rdc("post-reset cnt_l", 3'd4, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
